// File: rtl/i2c_pkg.sv
// Shared types for the I2C bus monitor: FSM state, byte width, completed-byte record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_SHIFT,
    MON_ACK
  } i2c_mon_state_e;

  localparam int I2C_BITS_PER_BYTE = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       first;
  } i2c_byte_t;

endpackage

// File: rtl/i2c_cond_detect.sv
// I2C condition decode: registers SCL/SDA and flags SCL rise, START and STOP.
// Latency: outputs are combinational against the previous-cycle levels.
// Backpressure: none; a pure observer of the bus.
module i2c_cond_detect (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic start,
  output logic stop
);

  logic scl_q;
  logic sda_q;

  // Previous-cycle bus levels; idle bus reads high on both lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_i;
      sda_q <= sda_i;
    end
  end

  // START/STOP need SCL high on both samples, so a simultaneous SCL+SDA
  // change can only ever register as an SCL edge.
  assign scl_rise = scl_i & ~scl_q;
  assign start    = scl_q & scl_i & sda_q & ~sda_i;
  assign stop     = scl_q & scl_i & ~sda_q & sda_i;

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: START/rSTART/STOP detect and byte+ACK deserialiser (optional macro I2C_BUS_MONITOR_ADDR_MATCH_EN).
// Latency: pulses, busy_o and byte_valid_o change one cycle after the condition is visible on scl_i/sda_i.
// Backpressure: one-entry valid/ready byte register; a byte completing while it is full is dropped with overflow_o.
module i2c_bus_monitor
  import i2c_pkg::*;
`ifdef I2C_BUS_MONITOR_ADDR_MATCH_EN
#(
  parameter int                ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] TGT_ADDR = 7'h50
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       start_o,
  output logic       rstart_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic [7:0] byte_data_o,
  output logic       byte_ack_o,
  output logic       byte_first_o,
  output logic       overflow_o,
  output logic       abort_o
`ifdef I2C_BUS_MONITOR_ADDR_MATCH_EN
  ,
  output logic       addr_match_o
`endif
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(I2C_BITS_PER_BYTE - 1);

  logic scl_rise, cond_start, cond_stop;

  i2c_cond_detect u_cond (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .start    (cond_start),
    .stop     (cond_stop)
  );

  i2c_mon_state_e state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           first_q, first_d;
  logic           start_q, start_d;
  logic           rstart_q, rstart_d;
  logic           stop_q, stop_d;
  logic           abort_q, abort_d;
  logic           byte_done;
  logic           mid_byte;

  i2c_byte_t      hold_q;
  logic           valid_q;
  logic           overflow_q;

  // Any bit clocked in, or sitting in the ACK slot, means a byte is in flight.
  assign mid_byte = (bit_cnt_q != 4'd0) || (state_q == MON_ACK);

  // FSM state, bit counter, shifter and the registered event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MON_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      first_q   <= 1'b0;
      start_q   <= 1'b0;
      rstart_q  <= 1'b0;
      stop_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      first_q   <= first_d;
      start_q   <= start_d;
      rstart_q  <= rstart_d;
      stop_q    <= stop_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state: bus conditions take priority; SCL rises clock bits in.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    first_d   = first_q;
    start_d   = 1'b0;
    rstart_d  = 1'b0;
    stop_d    = 1'b0;
    abort_d   = 1'b0;
    byte_done = 1'b0;
    case (state_q)
      MON_IDLE: begin
        if (cond_start) begin
          state_d   = MON_SHIFT;
          bit_cnt_d = 4'd0;
          first_d   = 1'b1;
          start_d   = 1'b1;
        end else if (cond_stop) begin
          stop_d = 1'b1;
        end
      end
      MON_SHIFT, MON_ACK: begin
        if (cond_start) begin
          state_d   = MON_SHIFT;
          bit_cnt_d = 4'd0;
          first_d   = 1'b1;
          rstart_d  = 1'b1;
          abort_d   = mid_byte;
        end else if (cond_stop) begin
          state_d   = MON_IDLE;
          bit_cnt_d = 4'd0;
          stop_d    = 1'b1;
          abort_d   = mid_byte;
        end else if (scl_rise) begin
          if (state_q == MON_SHIFT) begin
            shift_d   = {shift_q[6:0], sda_i};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_DATA_BIT) begin
              state_d = MON_ACK;
            end
          end else begin
            byte_done = 1'b1;
            first_d   = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = MON_SHIFT;
          end
        end
      end
      default: state_d = MON_IDLE;
    endcase
  end

  // One-entry output register: load on completion if empty or draining, else flag overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (byte_done) begin
        if (!valid_q || byte_ready_i) begin
          hold_q.data  <= shift_q;
          hold_q.ack   <= sda_i;
          hold_q.first <= first_q;
          valid_q      <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (valid_q && byte_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef I2C_BUS_MONITOR_ADDR_MATCH_EN
  logic match_q;

  // Address match travels with the byte it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else if (byte_done && (!valid_q || byte_ready_i)) begin
      match_q <= first_q && (shift_q[7 -: ADDR_W] == TGT_ADDR);
    end
  end

  assign addr_match_o = match_q;
`endif

  assign start_o      = start_q;
  assign rstart_o     = rstart_q;
  assign stop_o       = stop_q;
  assign abort_o      = abort_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != MON_IDLE);
  assign byte_valid_o = valid_q;
  assign byte_data_o  = hold_q.data;
  assign byte_ack_o   = hold_q.ack;
  assign byte_first_o = hold_q.first;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor with a queue scoreboard for events and bytes.
// Latency: expects every pulse and byte_valid_o one cycle after the bus condition.
// Backpressure: byte_ready_i is held high or low per scenario.
module tb_i2c_bus_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_i = 1'b1;
  logic       sda_i = 1'b1;
  logic       byte_ready_i = 1'b0;
  logic       start_o, rstart_o, stop_o, busy_o, byte_valid_o;
  logic [7:0] byte_data_o;
  logic       byte_ack_o, byte_first_o, overflow_o, abort_o;
`ifdef I2C_BUS_MONITOR_ADDR_MATCH_EN
  logic       addr_match_o;
`endif

  i2c_bus_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .start_o      (start_o),
    .rstart_o     (rstart_o),
    .stop_o       (stop_o),
    .busy_o       (busy_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .byte_data_o  (byte_data_o),
    .byte_ack_o   (byte_ack_o),
    .byte_first_o (byte_first_o),
    .overflow_o   (overflow_o),
    .abort_o      (abort_o)
`ifdef I2C_BUS_MONITOR_ADDR_MATCH_EN
    ,
    .addr_match_o (addr_match_o)
`endif
  );

  always #5 clk = ~clk;

  // Event vector layout: {start, rstart, stop, abort, overflow}
  localparam logic [4:0] EV_START  = 5'b10000;
  localparam logic [4:0] EV_RSTART = 5'b01000;
  localparam logic [4:0] EV_STOP   = 5'b00100;
  localparam logic [4:0] EV_ABORT  = 5'b00010;
  localparam logic [4:0] EV_OVF    = 5'b00001;

  typedef struct packed {
    logic [7:0] d;
    logic       a;
    logic       f;
    logic       m;
  } exp_byte_t;

  logic [4:0] ev_q[$];
  exp_byte_t  byte_q[$];
  int         n_tests = 0;
  int         n_fail = 0;

  logic [4:0] mon_ev;
  logic [4:0] mon_exp_ev;
  exp_byte_t  mon_exp_b;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every pulse and every accepted byte against the queues.
  always @(negedge clk) begin
    mon_ev = {start_o, rstart_o, stop_o, abort_o, overflow_o};
    if (!rst && mon_ev != 5'b0) begin
      n_tests++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL event_unexpected: got %b expected none", mon_ev);
      end else begin
        mon_exp_ev = ev_q.pop_front();
        if (mon_ev !== mon_exp_ev) begin
          n_fail++;
          $display("FAIL event: got %b expected %b", mon_ev, mon_exp_ev);
        end
      end
    end
    if (!rst && byte_valid_o && byte_ready_i) begin
      n_tests++;
      if (byte_q.size() == 0) begin
        n_fail++;
        $display("FAIL byte_unexpected: got data 0x%0h", byte_data_o);
      end else begin
        mon_exp_b = byte_q.pop_front();
        if ({byte_data_o, byte_ack_o, byte_first_o} !== {mon_exp_b.d, mon_exp_b.a, mon_exp_b.f}) begin
          n_fail++;
          $display("FAIL byte: got data 0x%0h ack %b first %b expected data 0x%0h ack %b first %b",
                   byte_data_o, byte_ack_o, byte_first_o, mon_exp_b.d, mon_exp_b.a, mon_exp_b.f);
        end
`ifdef I2C_BUS_MONITOR_ADDR_MATCH_EN
        n_tests++;
        if (addr_match_o !== mon_exp_b.m) begin
          n_fail++;
          $display("FAIL addr_match: got %b expected %b (data 0x%0h)", addr_match_o, mon_exp_b.m, mon_exp_b.d);
        end
`endif
      end
    end
  end

  task automatic set_bus(input logic s, input logic d);
    @(posedge clk);
    #1;
    scl_i = s;
    sda_i = d;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    set_bus(1'b0, sda_i);
    set_bus(1'b0, b);
    set_bus(1'b1, b);
  endtask

  task automatic start_cond();
    ev_q.push_back(EV_START);
    set_bus(1'b1, 1'b1);
    set_bus(1'b1, 1'b0);
  endtask

  // The SCL rise needed to re-arm SDA high is clocked as a data bit, so rSTART aborts.
  task automatic rstart_cond();
    ev_q.push_back(EV_RSTART | EV_ABORT);
    set_bus(1'b0, sda_i);
    set_bus(1'b0, 1'b1);
    set_bus(1'b1, 1'b1);
    set_bus(1'b1, 1'b0);
  endtask

  task automatic stop_cond(input bit exp_abort);
    if (scl_i && !sda_i) begin
      ev_q.push_back(exp_abort ? (EV_STOP | EV_ABORT) : EV_STOP);
      set_bus(1'b1, 1'b1);
    end else begin
      ev_q.push_back(EV_STOP | EV_ABORT);
      set_bus(1'b0, sda_i);
      set_bus(1'b0, 1'b0);
      set_bus(1'b1, 1'b0);
      set_bus(1'b1, 1'b1);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic a, input logic f, input logic m,
                           input bit push, input bit ovf);
    exp_byte_t e;
    e.d = d;
    e.a = a;
    e.f = f;
    e.m = m;
    if (push) byte_q.push_back(e);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    if (ovf) ev_q.push_back(EV_OVF);
    send_bit(a);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outputs",
          {24'd0, start_o, rstart_o, stop_o, abort_o, overflow_o, busy_o, byte_valid_o, byte_ack_o},
          32'd0);
    check("reset_data", {23'd0, byte_data_o, byte_first_o}, 32'd0);

    // 1: single byte A5 ACK, clean STOP straight from SCL high
    byte_ready_i = 1'b1;
    start_cond();
    #1 check("s1_busy_after_start", {31'd0, busy_o}, 32'd1);
    send_byte(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    stop_cond(1'b0);
    #1 check("s1_busy_after_stop", {31'd0, busy_o}, 32'd0);

    // 2: A0 ACK, repeated START, A1 NACK, STOP
    start_cond();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    rstart_cond();
    #1 check("s2_busy_after_rstart", {31'd0, busy_o}, 32'd1);
    send_byte(8'hA1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 check("s2_busy_before_stop", {31'd0, busy_o}, 32'd1);
    stop_cond(1'b1);
    #1 check("s2_busy_after_stop", {31'd0, busy_o}, 32'd0);

    // 3: two bytes with no consumer; second one overflows and is dropped
    byte_ready_i = 1'b0;
    start_cond();
    send_byte(8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop_cond(1'b0);
    #1 check("s3_held_data", {24'd0, byte_data_o}, 32'h11);
    check("s3_held_valid", {31'd0, byte_valid_o}, 32'd1);
    byte_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("s3_drained", {31'd0, byte_valid_o}, 32'd0);

    // 4: three bits then STOP -> abort with stop, nothing presented
    start_cond();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    stop_cond(1'b1);
    #1 check("s4_valid", {31'd0, byte_valid_o}, 32'd0);
    check("s4_busy", {31'd0, busy_o}, 32'd0);

    // 5: simultaneous SCL/SDA changes, then reset mid-byte with a held byte
    set_bus(1'b1, 1'b1);
    set_bus(1'b0, 1'b0);
    set_bus(1'b1, 1'b1);
    #1 check("s5_glitch_busy", {31'd0, busy_o}, 32'd0);
    byte_ready_i = 1'b0;
    start_cond();
    send_byte(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    #1 check("s5_held_before_reset", {23'd0, byte_valid_o, byte_data_o}, {23'd0, 1'b1, 8'h3C});
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("s5_reset_outputs",
          {24'd0, start_o, rstart_o, stop_o, abort_o, overflow_o, busy_o, byte_valid_o, byte_ack_o},
          32'd0);
    check("s5_reset_data", {23'd0, byte_data_o, byte_first_o}, 32'd0);
    byte_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("s5_idle_after_reset", {30'd0, busy_o, byte_valid_o}, 32'd0);

`ifdef I2C_BUS_MONITOR_ADDR_MATCH_EN
    // Address match: first byte A0 matches 0x50, a data byte A0 does not, address A2 does not
    start_cond();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send_byte(8'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rstart_cond();
    send_byte(8'hA2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    stop_cond(1'b1);
`endif

    repeat (20) @(posedge clk);
    #1 check("events_outstanding", ev_q.size(), 32'd0);
    check("bytes_outstanding", byte_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
